// File: rtl/iir_pkg.sv
// Shared definitions for the IIR settle meter.
// Contents:
//   state_t      - measurement FSM state encoding (IDLE, TRACK, DONE)
//   CNT_W        - width of the sample/run/index counters
//   *_DEFAULT    - default tolerance, run length and timeout
package iir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CNT_W        = 16;
  localparam int NTOL_DEFAULT = 64;
  localparam int NRUN_DEFAULT = 8;
  localparam int NMAX_DEFAULT = 1000;

endpackage

// File: rtl/iir_band_check.sv
// Combinational tolerance-band test for one sample.
// The error is formed one bit wider than the sample word, so the
// subtraction cannot wrap. Its magnitude is then compared against Ntol,
// and the bound is inclusive.
// Ports:
//   d       in  W    signed sample
//   tgt     in  W    signed target value
//   in_band out 1    1 when |d - tgt| <= Ntol
module iir_band_check
  import iir_pkg::*;
#(
  parameter int W    = 25,
  parameter int Ntol = NTOL_DEFAULT
) (
  input  logic signed [W-1:0] d,
  input  logic signed [W-1:0] tgt,
  output logic                in_band
);

  logic signed [W:0] err;
  logic        [W:0] abs_err;

  always_comb begin
    err     = $signed({d[W-1], d}) - $signed({tgt[W-1], tgt});
    // The most negative possible error is -(2^W - 1). Its negation
    // therefore still fits in W+1 unsigned bits.
    abs_err = err[W] ? $unsigned(-err) : $unsigned(err);
    in_band = (abs_err <= (W+1)'(Ntol));
  end

endmodule

// File: rtl/iir_settle_meter.sv
// Settling-time meter for a filter output stream.
// A start pulse latches the target and begins a measurement. From then on,
// each strobed sample is checked against the target tolerance band. The
// measurement ends in one of two ways:
//   - Settle: a run of Nrun consecutive in-band samples is seen.
//   - Timeout: Nmax samples have been observed.
// On completion, done pulses for one cycle and the results are held until
// the next start.
// Optional feature (macro IIR_SETTLE_PEAK_EN): track the peak sample and the
// overshoot above the target. When the macro is undefined, both outputs are
// tied to 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse that (re)starts a measurement
//   target       signed expected final value, sampled on start
//   dv_in, d_in  sample strobe and signed sample
//   busy         1 while a measurement is in progress
//   done         one-cycle completion pulse
//   settled      1 = settled, 0 = timed out
//   settle_idx   index of the first sample of the final in-band run
//                (0xFFFF on timeout)
//   peak         maximum sample seen during the measurement
//   overshoot    peak - target, clamped at 0
module iir_settle_meter
  import iir_pkg::*;
#(
  parameter int Ndint  = 3,
  parameter int Ndfrac = 22,
  parameter int Ntol   = NTOL_DEFAULT,
  parameter int Nrun   = NRUN_DEFAULT,
  parameter int Nmax   = NMAX_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic signed [Ndint+Ndfrac-1:0]  target,
  input  logic                            dv_in,
  input  logic signed [Ndint+Ndfrac-1:0]  d_in,
  output logic                            busy,
  output logic                            done,
  output logic                            settled,
  output logic        [CNT_W-1:0]         settle_idx,
  output logic signed [Ndint+Ndfrac-1:0]  peak,
  output logic        [Ndint+Ndfrac:0]    overshoot
);

  localparam int W = Ndint + Ndfrac;

  state_t                 state_reg;
  logic signed [W-1:0]    target_reg;
  logic [CNT_W-1:0]       sample_cnt_reg;
  logic [CNT_W-1:0]       run_cnt_reg;
  logic [CNT_W-1:0]       run_start_reg;
  logic [CNT_W-1:0]       settle_idx_reg;
  logic                   settled_reg;
  logic                   done_reg;
  logic                   busy_reg;

  logic                   in_band;
  logic [CNT_W-1:0]       sample_inc;
  logic [CNT_W-1:0]       run_inc;
  logic [CNT_W-1:0]       run_first;
  logic                   hit_settle;
  logic                   hit_timeout;

  iir_band_check #(
    .W    (W),
    .Ntol (Ntol)
  ) u_band (
    .d       (d_in),
    .tgt     (target_reg),
    .in_band (in_band)
  );

  always_comb begin
    sample_inc  = sample_cnt_reg + 16'd1;
    run_inc     = run_cnt_reg + 16'd1;
    // The run start must be visible on the same sample that completes the
    // run. This matters when Nrun = 1.
    run_first   = (run_cnt_reg == '0) ? sample_cnt_reg : run_start_reg;
    hit_settle  = in_band && (run_inc == CNT_W'(Nrun));
    hit_timeout = (sample_inc == CNT_W'(Nmax));
  end

`ifdef IIR_SETTLE_PEAK_EN
  logic signed [W-1:0] peak_reg;
  logic signed [W:0]   ovs_diff;

  always_comb begin
    ovs_diff = $signed({peak_reg[W-1], peak_reg}) - $signed({target_reg[W-1], target_reg});
  end

  assign peak      = peak_reg;
  assign overshoot = ovs_diff[W] ? '0 : $unsigned(ovs_diff);
`else
  assign peak      = '0;
  assign overshoot = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      target_reg     <= '0;
      sample_cnt_reg <= '0;
      run_cnt_reg    <= '0;
      run_start_reg  <= '0;
      settle_idx_reg <= '0;
      settled_reg    <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef IIR_SETTLE_PEAK_EN
      peak_reg       <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      // start wins in every state: it restarts an ongoing measurement
      // silently, and it is accepted directly out of DONE.
      if (start) begin
        state_reg      <= ST_TRACK;
        busy_reg       <= 1'b1;
        target_reg     <= target;
        sample_cnt_reg <= '0;
        run_cnt_reg    <= '0;
        run_start_reg  <= '0;
        settle_idx_reg <= '0;
        settled_reg    <= 1'b0;
`ifdef IIR_SETTLE_PEAK_EN
        peak_reg       <= {1'b1, {(W-1){1'b0}}};
`endif
      end else begin
        case (state_reg)
          ST_TRACK: begin
            if (dv_in) begin
              sample_cnt_reg <= sample_inc;
              if (in_band) begin
                run_cnt_reg   <= run_inc;
                run_start_reg <= run_first;
              end else begin
                run_cnt_reg   <= '0;
              end
`ifdef IIR_SETTLE_PEAK_EN
              if (d_in > peak_reg) peak_reg <= d_in;
`endif
              // Settle is checked before timeout, so it has priority when
              // both happen on the same sample.
              if (hit_settle) begin
                settled_reg    <= 1'b1;
                settle_idx_reg <= run_first;
                done_reg       <= 1'b1;
                busy_reg       <= 1'b0;
                state_reg      <= ST_DONE;
              end else if (hit_timeout) begin
                settled_reg    <= 1'b0;
                settle_idx_reg <= '1;
                done_reg       <= 1'b1;
                busy_reg       <= 1'b0;
                state_reg      <= ST_DONE;
              end
            end
          end
          ST_DONE:  state_reg <= ST_IDLE;
          default:  state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign settled    = settled_reg;
  assign settle_idx = settle_idx_reg;

endmodule

// File: tb/tb_iir_settle_meter.sv
// Self-checking bench for iir_settle_meter (default parameters).
// Tests are driven in three ways:
//   - A table of directed vectors.
//   - Hand-written sequences: alternating timeout, step response,
//     restart mid-measurement and reset mid-measurement.
//   - Randomized sample streams scored by a reference model.
// Expected peak/overshoot follow the IIR_SETTLE_PEAK_EN build option.
`timescale 1ns/1ps
module tb_iir_settle_meter;

  localparam int     W    = 25;
  localparam longint TOL  = 64;
  localparam int     NRUN = 8;
  localparam int     NMAX = 1000;

  typedef logic signed [63:0] val_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic dv_in = 1'b0;
  logic signed [W-1:0] target = '0;
  logic signed [W-1:0] d_in = '0;
  logic busy, done, settled;
  logic [15:0] settle_idx;
  logic signed [W-1:0] peak;
  logic [W:0] overshoot;

  int checks = 0;
  int failures = 0;
  longint samp_q[$];

  always #5 clk = ~clk;

  iir_settle_meter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .target     (target),
    .dv_in      (dv_in),
    .d_in       (d_in),
    .busy       (busy),
    .done       (done),
    .settled    (settled),
    .settle_idx (settle_idx),
    .peak       (peak),
    .overshoot  (overshoot)
  );

  task automatic chk(input string name, input val_t act, input val_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: scan the sample stream with the settle rules directly.
  task automatic model_run(input longint tgt, output int last, output bit sett, output int idx);
    int run;
    int rs;
    longint e;
    run = 0; rs = 0; last = -1; sett = 1'b0; idx = 0;
    for (int i = 0; i < samp_q.size(); i++) begin
      e = samp_q[i] - tgt;
      if (e >= -TOL && e <= TOL) begin
        if (run == 0) rs = i;
        run++;
      end else begin
        run = 0;
      end
      if (run == NRUN) begin sett = 1'b1; idx = rs; last = i; return; end
      if (i + 1 == NMAX) begin sett = 1'b0; idx = 16'hFFFF; last = i; return; end
    end
  endtask

  // Start a measurement. Then feed samp_q[0..last], with random idle gaps.
  // After that, check the completion timing and the results. Finally, check
  // that the results hold while extra strobes are ignored.
  task automatic measure(input string name, input longint tgt, input int last,
                         input bit exp_sett, input int exp_idx, input int max_gap);
    longint pk;
    bit     early;
    bit     late_done;
    val_t   exp_pk;
    val_t   exp_ovs;
    @(negedge clk);
    start = 1'b1; target = W'(tgt);
    @(negedge clk);
    start = 1'b0;
    chk({name, ".busy_on_start"}, busy, 1);
    pk = -(longint'(1) <<< (W-1));
    early = 1'b0;
    for (int i = 0; i <= last; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        if (done || !busy) early = 1'b1;
      end
      dv_in = 1'b1; d_in = W'(samp_q[i]);
      if (samp_q[i] > pk) pk = samp_q[i];
      @(negedge clk);
      dv_in = 1'b0;
      if (i < last && (done || !busy)) early = 1'b1;
    end
    chk({name, ".early_end"}, early, 0);
    chk({name, ".done"}, done, 1);
    chk({name, ".busy_at_done"}, busy, 0);
    chk({name, ".settled"}, settled, exp_sett);
    chk({name, ".settle_idx"}, settle_idx, exp_idx);
`ifdef IIR_SETTLE_PEAK_EN
    exp_pk  = pk;
    exp_ovs = (pk > tgt) ? (pk - tgt) : 0;
`else
    exp_pk  = 0;
    exp_ovs = 0;
`endif
    chk({name, ".peak"}, peak, exp_pk);
    chk({name, ".overshoot"}, overshoot, exp_ovs);
    late_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dv_in = 1'b1; d_in = W'(tgt + 300 * (k + 1));
      @(negedge clk);
      if (done || busy) late_done = 1'b1;
    end
    dv_in = 1'b0;
    chk({name, ".quiet_after"}, late_done, 0);
    chk({name, ".hold_idx"}, settle_idx, exp_idx);
    chk({name, ".hold_peak"}, peak, exp_pk);
    $display("txn %s target=%0d samples=%0d settled=%0d settle_idx=%0d peak=%0d overshoot=%0d",
             name, tgt, last + 1, settled, settle_idx, peak, overshoot);
  endtask

  typedef struct {
    longint tgt;
    longint base_err;
    int     brk_pos;
    longint brk_err;
    int     nsamp;
    bit     exp_sett;
    int     exp_idx;
    int     exp_last;
  } vec_t;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[8];
    int   last;
    bit   sett;
    int   idx;
    bit   bad;
    longint tgt;
    real  b0, b1, b2, a1, a2, x1, x2, y, y1, y2;

    vecs[0] = '{64'sh400000,    0, -1,    0,    8, 1'b1, 0,     7};
    vecs[1] = '{64'sh400000,   64, -1,    0,    8, 1'b1, 0,     7};
    vecs[2] = '{64'sh400000,  -64, -1,    0,    8, 1'b1, 0,     7};
    vecs[3] = '{64'sh400000,    0,  5,   65,   14, 1'b1, 6,    13};
    vecs[4] = '{64'sh400000,    0,  5,  -65,   14, 1'b1, 6,    13};
    vecs[5] = '{64'sh400000,    0,  5,   64,    8, 1'b1, 0,     7};
    vecs[6] = '{-64'sh100000,  10,  7, 1000,   16, 1'b1, 8,    15};
    vecs[7] = '{64'sh10,       65, -1,    0, 1000, 1'b0, 65535, 999};

    // Reset state
    #12;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.settled", settled, 0);
    chk("reset.settle_idx", settle_idx, 0);
    chk("reset.peak", peak, 0);
    chk("reset.overshoot", overshoot, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      samp_q.delete();
      for (int i = 0; i < vecs[v].nsamp; i++)
        samp_q.push_back(vecs[v].tgt + ((i == vecs[v].brk_pos) ? vecs[v].brk_err : vecs[v].base_err));
      measure($sformatf("vec%0d", v), vecs[v].tgt, vecs[v].exp_last,
              vecs[v].exp_sett, vecs[v].exp_idx, 1);
    end

    // Alternating target +/- 200 LSB: must time out at sample 1000
    samp_q.delete();
    for (int i = 0; i < 1000; i++) samp_q.push_back(64'sh400000 + ((i % 2) ? -200 : 200));
    measure("alternate", 64'sh400000, 999, 1'b0, 65535, 1);

    // Step response of butter(2,0.25) biquad, quantised to Q3.22
    b0 = 0.0976310729378175; b1 = 0.195262145875635; b2 = 0.0976310729378175;
    a1 = -0.942809041582063; a2 = 0.333333333333333;
    x1 = 0.0; x2 = 0.0; y1 = 0.0; y2 = 0.0;
    samp_q.delete();
    for (int n = 0; n < 200; n++) begin
      y  = b0 + b1 * x1 + b2 * x2 - a1 * y1 - a2 * y2;
      x2 = x1; x1 = 1.0; y2 = y1; y1 = y;
      samp_q.push_back(longint'(y * 4194304.0));
    end
    model_run(64'sh400000, last, sett, idx);
    chk("step.model_settles", sett, 1);
    if (last >= 0) begin
      measure("step", 64'sh400000, last, sett, idx, 2);
`ifdef IIR_SETTLE_PEAK_EN
      chk("step.overshoot_positive", overshoot > 0, 1);
`endif
    end

    // Restart mid-TRACK: 5 in-band samples, then a fresh start must need 8 more
    @(negedge clk);
    start = 1'b1; target = W'(64'sh200000);
    @(negedge clk);
    start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dv_in = 1'b1; d_in = W'(64'sh200000);
      @(negedge clk);
      dv_in = 1'b0;
      if (done || !busy) bad = 1'b1;
    end
    chk("restart.partial_quiet", bad, 0);
    samp_q.delete();
    for (int i = 0; i < 8; i++) samp_q.push_back(64'sh200000 + 3);
    measure("restart", 64'sh200000, 7, 1'b1, 0, 0);

    // Reset pulse mid-TRACK: everything cleared, no done afterwards
    @(negedge clk);
    start = 1'b1; target = W'(64'sh300000);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dv_in = 1'b1; d_in = W'(64'sh300000 + 500);
      @(negedge clk);
    end
    dv_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.busy", busy, 0);
    chk("midreset.settled", settled, 0);
    chk("midreset.settle_idx", settle_idx, 0);
    chk("midreset.peak", peak, 0);
    chk("midreset.overshoot", overshoot, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      dv_in = 1'b1; d_in = W'(64'sh300000);
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    dv_in = 1'b0;
    chk("midreset.idle_ignores_dv", bad, 0);
    $display("txn midreset target=%0d busy=%0d done=%0d", 64'sh300000, busy, done);

    // Randomized streams scored by the model
    for (int t = 0; t < 6; t++) begin
      tgt = longint'($urandom_range(0, 32'h800000)) - 64'sh400000;
      samp_q.delete();
      for (int i = 0; i < NMAX; i++) begin
        if ($urandom_range(0, 99) < 80)
          samp_q.push_back(tgt + longint'($urandom_range(0, 128)) - 64);
        else if ($urandom_range(0, 1) == 1)
          samp_q.push_back(tgt + longint'($urandom_range(65, 400)));
        else
          samp_q.push_back(tgt - longint'($urandom_range(65, 400)));
      end
      model_run(tgt, last, sett, idx);
      measure($sformatf("rand%0d", t), tgt, last, sett, idx, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
